// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] INST_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of (pc, inst) entries; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push_valid,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop_ready,
    output fetch_entry_t             o_pop_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign o_full  = (o_count == (AW + 1)'(DEPTH));
    assign o_empty = (o_count == '0);
    assign pop     = i_pop_ready && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push    = i_push_valid && (!o_full || pop);

    // Head is read from registered storage and forced to zero while empty.
    assign o_pop_data = o_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   o_count <= o_count + CNT_ONE;
                2'b01:   o_count <= o_count - CNT_ONE;
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order word requests, response
// buffering with PC tagging, and redirect handling that drops stale responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_inst_ready
);

    // Handshakes: a transfer happens in a cycle where valid && ready at the
    // rising edge; valid never depends on ready. Responses carry no ready and
    // are always taken.
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   credit_used;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   target_pc;
    logic          fifo_full;
    logic          fifo_empty;
    logic          issue_room;
    logic          req_fire;
    logic          rsp_keep;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Buffered plus outstanding fetches never exceed DEPTH, so every
    // returning response is guaranteed a FIFO slot.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue_room  = !fifo_full && (credit_used < (CW + 1)'(DEPTH));

    assign o_imem_req_valid = !i_rst && !i_redirect && issue_room;
    assign o_imem_req_addr  = fetch_pc;
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

    assign rsp_keep   = i_imem_rsp_valid && !i_redirect && (drop_cnt == '0);
    assign push_entry = '{pc: rsp_pc, inst: i_imem_rsp_data};
    assign target_pc  = word_align(i_redirect_pc);

    assign inflight_next = inflight + CW'(req_fire) - CW'(i_imem_rsp_valid);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc <= word_align(RESET_PC);
            rsp_pc   <= word_align(RESET_PC);
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            if (i_redirect) begin
                // Everything still outstanding after this cycle is stale.
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                drop_cnt <= inflight_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + INST_BYTES;
                end
                if (i_imem_rsp_valid) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - CW'(1);
                    end else begin
                        rsp_pc <= rsp_pc + INST_BYTES;
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_redirect),
        .i_push_valid(rsp_keep),
        .i_push_data (push_entry),
        .i_pop_ready (i_inst_ready && !i_redirect),
        .o_pop_data  (head),
        .o_count     (fifo_count),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    assign o_inst_valid = !fifo_empty;
    assign o_inst       = head.inst;
    assign o_pc         = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences and a
// randomized run against a queue-based memory and fetch-stream model.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        inst_ready;

    fetch_unit #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_redirect      (redirect),
        .i_redirect_pc   (redirect_pc),
        .o_imem_req_valid(o_imem_req_valid),
        .o_imem_req_addr (o_imem_req_addr),
        .i_imem_req_ready(imem_req_ready),
        .i_imem_rsp_valid(imem_rsp_valid),
        .i_imem_rsp_data (imem_rsp_data),
        .o_inst_valid    (o_inst_valid),
        .o_inst          (o_inst),
        .o_pc            (o_pc),
        .i_inst_ready    (inst_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } out_t;

    typedef struct {
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_inst_valid;
        logic [31:0] exp_pc;
    } vec_t;

    mem_req_t    mq[$];
    out_t        mfifo[$];
    int          m_drop;
    logic [31:0] exp_req_pc;
    logic [31:0] m_rsp_pc;
    int          cyc;
    int          lat_min;
    int          lat_max;
    logic        rdy_random;
    logic        s_rsp;
    logic        s_fire;
    logic        s_deliver;
    int          n_fire;
    logic [31:0] last_fire_addr;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- driver: present memory side, sample and compare ----------------
    task automatic drive_sample();
        logic exp_rv;
        s_rsp          = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = s_rsp;
        imem_rsp_data  = s_rsp ? mq[0].data : 32'h0;
        imem_req_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        exp_rv = !rst && !redirect && ((mfifo.size() + mq.size()) < DEPTH);
        check_bit("req_valid", o_imem_req_valid, exp_rv);
        if (exp_rv) check_word("req_addr", o_imem_req_addr, exp_req_pc);
        check_bit("inst_valid", o_inst_valid, mfifo.size() > 0);
        if (mfifo.size() > 0) begin
            check_word("head_pc", o_pc, mfifo[0].pc);
            check_word("head_inst", o_inst, mfifo[0].inst);
        end
        check_bit("pc_aligned", o_pc[1:0] == 2'b00, 1'b1);
        check_bit("inv_drop_le_inflight", dut.drop_cnt <= dut.inflight, 1'b1);
        check_bit("inv_inflight_le_depth", int'(dut.inflight) <= DEPTH, 1'b1);
        check_bit("inv_no_overflow", (int'(dut.fifo_count) + int'(dut.inflight)) <= DEPTH, 1'b1);
        s_fire    = exp_rv && imem_req_ready;
        s_deliver = (mfifo.size() > 0) && inst_ready;
    endtask

    // ---------------- reference model update at the clock edge ----------------
    task automatic advance();
        mem_req_t e;
        int       due;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mfifo.delete();
            m_drop     = 0;
            exp_req_pc = RESET_PC;
            m_rsp_pc   = RESET_PC;
        end else if (redirect) begin
            if (s_rsp) void'(mq.pop_front());
            m_drop = mq.size();
            mfifo.delete();
            exp_req_pc = {redirect_pc[31:2], 2'b00};
            m_rsp_pc   = {redirect_pc[31:2], 2'b00};
        end else begin
            if (s_deliver) void'(mfifo.pop_front());
            if (s_rsp) begin
                e = mq.pop_front();
                if (m_drop > 0) m_drop--;
                else begin
                    mfifo.push_back('{pc: m_rsp_pc, inst: e.data});
                    m_rsp_pc += 32'd4;
                end
            end
            if (s_fire) begin
                due = cyc + int'($urandom_range(lat_min, lat_max));
                if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
                mq.push_back('{addr: exp_req_pc, data: mem_word(exp_req_pc), due: due});
                n_fire++;
                last_fire_addr = exp_req_pc;
                exp_req_pc += 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick();
        drive_sample();
        advance();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for the next delivered instruction and check its PC.
    task automatic expect_first_delivery(input string name, input logic [31:0] want_pc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            drive_sample();
            if (o_inst_valid) begin
                seen = 1'b1;
                check_word(name, o_pc, want_pc);
            end
            advance();
        end
        if (!seen) check_bit({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[6];
    int   fires_before;

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        inst_ready = 1'b1;
        cyc = 0; n_checks = 0; n_fail = 0; n_fire = 0; last_fire_addr = 32'h0;
        m_drop = 0; exp_req_pc = RESET_PC; m_rsp_pc = RESET_PC;
        lat_min = 1; lat_max = 1; rdy_random = 1'b0;
        @(negedge clk);

        // Latency 1, everything ready: first few cycles after reset.
        vecs[0] = '{1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0004, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
        vecs[4] = '{1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
        vecs[5] = '{1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C};
        do_reset();
        drive_sample();
        check_bit("reset_inst_valid", o_inst_valid, 1'b0);
        check_word("reset_inst", o_inst, 32'h0);
        check_word("reset_pc", o_pc, 32'h0);
        advance();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_sample();
            check_bit($sformatf("tbl%0d_req_valid", i), o_imem_req_valid, vecs[i].exp_req_valid);
            check_word($sformatf("tbl%0d_req_addr", i), o_imem_req_addr, vecs[i].exp_req_addr);
            check_bit($sformatf("tbl%0d_inst_valid", i), o_inst_valid, vecs[i].exp_inst_valid);
            if (vecs[i].exp_inst_valid) check_word($sformatf("tbl%0d_pc", i), o_pc, vecs[i].exp_pc);
            advance();
        end

        // Core stalled: credits exhaust after DEPTH requests, head held.
        do_reset();
        inst_ready = 1'b0;
        n_fire = 0;
        repeat (8) tick();
        check_word("stall_fire_count", n_fire, DEPTH);
        check_word("stall_last_addr", last_fire_addr, 32'h0000_000C);
        drive_sample();
        check_bit("stall_req_valid", o_imem_req_valid, 1'b0);
        check_bit("stall_full_valid", o_inst_valid, 1'b1);
        check_word("stall_head_pc", o_pc, 32'h0);
        advance();
        inst_ready = 1'b1;
        fires_before = n_fire;
        for (int i = 0; i < 10 && n_fire == fires_before; i++) tick();
        check_word("resume_addr", last_fire_addr, 32'h0000_0010);

        // Redirect with two requests outstanding (latency 3).
        do_reset();
        lat_min = 3; lat_max = 3;
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check_word("redir_drop_cnt", 32'(dut.drop_cnt), 32'd2);
        drive_sample();
        check_word("redir_next_addr", o_imem_req_addr, 32'h0000_0100);
        check_bit("redir_flushed", o_inst_valid, 1'b0);
        advance();
        expect_first_delivery("redir_first_pc", 32'h0000_0100);

        // Redirect coinciding with a response and a dequeue (latency 2).
        do_reset();
        lat_min = 2; lat_max = 2;
        tick(); tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        drive_sample();
        check_bit("coinc_head_valid", o_inst_valid, 1'b1);
        advance();
        redirect = 1'b0;
        check_word("coinc_drop_cnt", 32'(dut.drop_cnt), 32'd1);
        expect_first_delivery("coinc_first_pc", 32'h0000_0200);

        // Reset mid-stream with three requests outstanding.
        do_reset();
        lat_min = 4; lat_max = 4;
        tick(); tick(); tick();
        check_word("midrst_inflight", 32'(dut.inflight), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_sample();
        check_bit("midrst_inst_valid", o_inst_valid, 1'b0);
        check_word("midrst_inst", o_inst, 32'h0);
        check_word("midrst_pc", o_pc, 32'h0);
        check_bit("midrst_req_valid", o_imem_req_valid, 1'b1);
        check_word("midrst_req_addr", o_imem_req_addr, RESET_PC);
        advance();
        repeat (20) tick();

        // Randomized traffic: memory stalls, latency 1..4, core backpressure, redirects.
        lat_min = 1; lat_max = 4; rdy_random = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            inst_ready  = 1'($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom;
            tick();
        end
        redirect = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. It sits directly upstream of the execute core and supplies the instruction word and its PC.
- Issues in-order word requests to instruction memory over a valid/ready request channel and accepts fixed-order responses with variable latency.
- Buffers returned (pc, inst) pairs in a small FIFO and presents them to the core with a valid/ready handshake.
- On a redirect (branch, jal, jalr) it flushes the FIFO and discards stale in-flight responses.

Parameters:
- DEPTH, 4, number of FIFO entries. Also the bound on buffered plus in-flight fetches. Must be a power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_redirect  input  1  core requests a fetch-stream change this cycle.
- i_redirect_pc  input  32  new fetch target; bits [1:0] are ignored.
- o_imem_req_valid  output  1  request valid.
- o_imem_req_addr  output  32  word-aligned fetch address.
- i_imem_req_ready  input  1  memory accepts the request.
- i_imem_rsp_valid  input  1  response valid. Responses return in request order; memory cannot stall them.
- i_imem_rsp_data  input  32  instruction word.
- o_inst_valid  output  1  FIFO head valid.
- o_inst  output  32  head instruction.
- o_pc  output  32  head PC.
- i_inst_ready  input  1  core consumes the head.

Behaviour:
- Reset (sync, i_rst=1 at a clock edge):
  - fetch_pc=RESET_PC.
  - FIFO empty; inflight=0; drop_cnt=0.
  - o_inst_valid=0, o_imem_req_valid=0, o_inst=0, o_pc=0.
  - Reset mid-operation abandons all in-flight requests. After reset the memory must also be reset, so late responses never arrive.
- Issue:
  - o_imem_req_valid = !i_rst && !i_redirect && (count + inflight < DEPTH).
  - o_imem_req_addr = fetch_pc.
  - On fire (valid && ready): fetch_pc += 4, wrapping modulo 2^32, and inflight += 1.
  - Requests are back-to-back capable: one per cycle at full throughput.
- Response:
  - Each rsp_valid decrements inflight.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise {rsp_pc, rsp_data} is enqueued. rsp_pc is a separate counter that advances by 4 per kept response.
  - Overflow is impossible by the issue credit rule. The bench asserts this.
- Output:
  - Registered FIFO head. A response in cycle t appears at the output in cycle t+1; there is no combinational bypass.
  - Dequeue when o_inst_valid && i_inst_ready.
  - Simultaneous enqueue and dequeue on a full FIFO is legal; count is unchanged.
- Redirect (highest priority; overrides dequeue, enqueue and issue in that cycle):
  - FIFO cleared, so o_inst_valid=0 next cycle.
  - fetch_pc and rsp_pc = {i_redirect_pc[31:2], 2'b00}.
  - drop_cnt <= inflight_next. This counts every outstanding request, including a response arriving this same cycle that is not enqueued. It means drop_cnt = inflight - rsp_valid.
  - Issue resumes the next cycle at the target.
- Back-to-back redirects: each redirect recomputes drop_cnt from the current inflight. The last target wins.
- Invariants (bench asserts):
  - drop_cnt ≤ inflight ≤ DEPTH.
  - count + inflight ≤ DEPTH.
  - o_pc is always word-aligned.
- Counter widths: $clog2(DEPTH)+1 bits, so the value DEPTH is representable.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] inst;}.
  - Constant INST_BYTES=4.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameterised by DEPTH.
  - Ports: i_clk, i_rst, i_flush, push/pop handshakes.
  - Reports count, full, empty.
  - Flush takes precedence over push and pop.

Test Plan:
- Reset release, memory latency 1, always ready, core always ready -> requests 0x0, 0x4, 0x8 on consecutive cycles. o_inst_valid first rises 2 cycles after the first request fire, with o_pc=0x0. The core then sees one instruction per cycle, PCs ascending by 4.
- Core holds i_inst_ready=0 with DEPTH=4 -> exactly 4 requests issue (0x0–0xC), then o_imem_req_valid=0. FIFO full, head o_pc=0x0 held stable. Releasing ready resumes issue at 0x10.
- Memory latency 3, 2 requests in flight, i_redirect with i_redirect_pc=0x103 -> FIFO flushed, drop_cnt=2. Both stale responses are discarded. Next request address is 0x100; the first delivered o_pc=0x100.
- Redirect in the same cycle as a valid response and a core dequeue -> response not enqueued, no dequeue, drop_cnt=inflight-1. No stale PC ever appears at the output.
- i_imem_req_ready toggled pseudo-randomly with latency 1–4 -> the delivered PC sequence is strictly +4 and the instruction data matches a memory model. The invariants hold throughout.
- Assert i_rst for 1 cycle mid-stream with 3 in flight -> next cycle all outputs are at reset values. The first request after reset is at RESET_PC.
